mult_div_unit: RTL and testbench

//  Sequential signed multiply/divide unit beside the ULA in the multicycle MIPS datapath.

---
 rtl/mult_div_unit.sv | 153 +++++++++++++++
 tb/tb_mult_div_unit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit: radix-2 Booth multiply, restoring divide, HI/LO result pair.
// Optional feature: define MDU_DIVZERO_EXC_EN to short-circuit divide-by-zero and expose DivZero.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
`ifdef MDU_DIVZERO_EXC_EN
  ,
  output logic             DivZero
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             isDiv;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH:0] mulAcc;
  logic             qm1;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             negQ;
  logic             negR;
`ifdef MDU_DIVZERO_EXC_EN
  logic             divZeroHit;
`endif

  logic [WIDTH:0]     mulUpper;
  logic [2*WIDTH+1:0] mulNext;
  logic [WIDTH:0]     remShift;
  logic [WIDTH+1:0]   remDiff;
  logic               borrow;
  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;

  // Upper half carries one guard bit so subtracting the most negative multiplicand cannot overflow.
  always_comb begin
    mulUpper = mulAcc[2*WIDTH:WIDTH];
    case ({mulAcc[0], qm1})
      2'b10:   mulUpper = mulUpper - {mcand[WIDTH-1], mcand};
      2'b01:   mulUpper = mulUpper + {mcand[WIDTH-1], mcand};
      default: mulUpper = mulAcc[2*WIDTH:WIDTH];
    endcase
    mulNext  = $signed({mulUpper, mulAcc[WIDTH-1:0], qm1}) >>> 1;
    remShift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    remDiff  = {1'b0, remShift} - {2'b00, dvs};
    borrow   = remDiff[WIDTH+1];
    aMag     = A[WIDTH-1] ? -A : A;
    bMag     = B[WIDTH-1] ? -B : B;
    quoFix   = negQ ? -quo : quo;
    remFix   = negR ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      isDiv  <= 1'b0;
      mcand  <= '0;
      mulAcc <= '0;
      qm1    <= 1'b0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      negQ   <= 1'b0;
      negR   <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Hi     <= '0;
      Lo     <= '0;
`ifdef MDU_DIVZERO_EXC_EN
      divZeroHit <= 1'b0;
      DivZero    <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
`ifdef MDU_DIVZERO_EXC_EN
      DivZero <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (Start) begin
            Busy   <= 1'b1;
            cnt    <= '0;
            isDiv  <= Op;
            mcand  <= A;
            mulAcc <= {{(WIDTH+1){1'b0}}, B};
            qm1    <= 1'b0;
            rem    <= '0;
            quo    <= aMag;
            dvs    <= bMag;
            negQ   <= A[WIDTH-1] ^ B[WIDTH-1];
            negR   <= A[WIDTH-1];
            state  <= Op ? DIV : MULT;
`ifdef MDU_DIVZERO_EXC_EN
            divZeroHit <= 1'b0;
            if (Op && (B == '0)) begin
              divZeroHit <= 1'b1;
              state      <= FINISH;
            end
`endif
          end
        end
        MULT: begin
          {mulAcc, qm1} <= mulNext;
          cnt           <= cnt + CW'(1);
          if (cnt == LAST) state <= FINISH;
        end
        DIV: begin
          rem <= borrow ? remShift : remDiff[WIDTH:0];
          quo <= {quo[WIDTH-2:0], ~borrow};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FINISH;
        end
        FINISH: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b1;
`ifdef MDU_DIVZERO_EXC_EN
          if (divZeroHit) begin
            DivZero <= 1'b1;
          end else
`endif
          if (isDiv) begin
            Hi <= remFix;
            Lo <= quoFix;
          end else begin
            Hi <= mulAcc[2*WIDTH-1:WIDTH];
            Lo <= mulAcc[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed products, quotients, latency, abort and ignore cases.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic         Op = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;
`ifdef MDU_DIVZERO_EXC_EN
  logic         DivZero;
`endif

  int checks = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
`ifdef MDU_DIVZERO_EXC_EN
    , .DivZero(DivZero)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic doOp(input string tag, input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input int expLat, input logic [W-1:0] expHi, input logic [W-1:0] expLo);
    logic [W-1:0] oldHi, oldLo;
    int n;
    oldHi = Hi;
    oldLo = Lo;
    Start = 1'b1; Op = op; A = a; B = b;
    tick();
    Start = 1'b0; A = 32'hDEADBEEF; B = 32'h12345678;
    chk({tag, "_busy"}, 64'(Busy), 64'd1);
    if (expLat > 2) chk({tag, "_holdMid"}, {Hi, Lo}, {oldHi, oldLo});
    n = 0;
    while (!Done && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(expLat));
    chk({tag, "_busyAtDone"}, 64'(Busy), 64'd0);
    chk({tag, "_hilo"}, {Hi, Lo}, {expHi, expLo});
`ifdef MDU_DIVZERO_EXC_EN
    chk({tag, "_divZero"}, 64'(DivZero), 64'((op && b == '0) ? 1 : 0));
`endif
    tick();
    chk({tag, "_donePulse"}, 64'(Done), 64'd0);
  endtask

  initial begin
    logic sawDone;
    tick();
    tick();
    chk("reset_outs", {60'd0, Busy, Done, 2'b00}, 64'd0);
    chk("reset_hilo", {Hi, Lo}, 64'd0);
    Reset = 1'b0;
    tick();

    doOp("mul_7x-3", 1'b0, 32'd7, 32'hFFFFFFFD, W + 1, 32'hFFFFFFFF, 32'hFFFFFFEB);
    doOp("mul_min2", 1'b0, 32'h80000000, 32'h80000000, W + 1, 32'h40000000, 32'h00000000);
    doOp("mul_neg2", 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA, W + 1, 32'h00000000, 32'h0000001E);
    doOp("mul_max2", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, W + 1, 32'h3FFFFFFF, 32'h00000001);
    doOp("div_100_7", 1'b1, 32'd100, 32'd7, W + 1, 32'd2, 32'd14);
    doOp("div_-100_7", 1'b1, 32'hFFFFFF9C, 32'd7, W + 1, 32'hFFFFFFFE, 32'hFFFFFFF2);
    doOp("div_7_-2", 1'b1, 32'd7, 32'hFFFFFFFE, W + 1, 32'd1, 32'hFFFFFFFD);
    doOp("div_min_-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, W + 1, 32'd0, 32'h80000000);
`ifdef MDU_DIVZERO_EXC_EN
    doOp("div_5_0", 1'b1, 32'd5, 32'd0, 1, 32'd0, 32'h80000000);
`else
    doOp("div_5_0", 1'b1, 32'd5, 32'd0, W + 1, 32'd5, 32'hFFFFFFFF);
    doOp("div_-5_0", 1'b1, 32'hFFFFFFFB, 32'd0, W + 1, 32'hFFFFFFFB, 32'd1);
`endif

    // Start 3*4, try a second Start mid-op, then abort with Reset.
    Start = 1'b1; Op = 1'b0; A = 32'd3; B = 32'd4;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    Start = 1'b1; A = 32'd9;
    tick();
    Start = 1'b0;
    chk("ignore_busy", 64'(Busy), 64'd1);
    repeat (9) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_hilo", {Hi, Lo}, 64'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Done) sawDone = 1'b1;
      tick();
    end
    chk("abort_noDone", 64'(sawDone), 64'd0);

    // Reset and Start together: the request is dropped.
    Reset = 1'b1; Start = 1'b1; A = 32'd6; B = 32'd6;
    tick();
    Reset = 1'b0; Start = 1'b0;
    tick();
    chk("resetWins_busy", 64'(Busy), 64'd0);

    doOp("restart_3x4", 1'b0, 32'd3, 32'd4, W + 1, 32'd0, 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
